game_fsm: RTL and testbench

- Parametrised successor to the top-level game flow controller.
- Sequences the game through title, play, pause, crash-burn animation and game-over.
- Tracks remaining lives and times the burn animation in frame ticks.
- Reacts to key press edges, not held keycodes.
- Sits between the USB keyboard keycode register and the sprite/physics blocks. It drives their Run, burn and respawn controls.

---
 rtl/game_pkg.sv | 15 +
 rtl/key_press_detect.sv | 28 ++
 rtl/game_fsm.sv | 119 +++++++++++
 tb/tb_game_fsm.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and keycode constants for the game flow controller.
package game_pkg;

    typedef enum logic [2:0] {
        START    = 3'd0,
        PLAY     = 3'd1,
        PAUSE    = 3'd2,
        BURN     = 3'd3,
        GAMEOVER = 3'd4
    } game_state_t;

    localparam logic [7:0] KEY_W = 8'd26;
    localparam logic [7:0] KEY_P = 8'd19;

endpackage

// File: rtl/key_press_detect.sv
// Turns a held keycode into a single-cycle press on its rising edge.
module key_press_detect #(
    parameter logic [7:0] KEY = 8'd0
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [7:0] keycode,
    output logic       press
);

    logic [7:0] key_prev_q;
    logic [7:0] key_prev_d;

    always_comb begin
        key_prev_d = keycode;
        press      = (keycode == KEY) && (key_prev_q != KEY);
    end

    // Clearing key_prev on reset means a key held through reset fires once.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            key_prev_q <= 8'd0;
        end else begin
            key_prev_q <= key_prev_d;
        end
    end

endmodule

// File: rtl/game_fsm.sv
// Top-level game flow: title, play, pause, crash-burn animation and game-over,
// with life accounting and a frame-timed burn dwell.
module game_fsm
    import game_pkg::*;
#(
    parameter int         NUM_LIVES   = 3,
    parameter int         BURN_FRAMES = 60,
    parameter logic [7:0] START_KEY   = KEY_W,
    parameter logic [7:0] PAUSE_KEY   = KEY_P,
    parameter int         LIVES_W     = $clog2(NUM_LIVES + 1)
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic [7:0]         keycode,
    input  logic               crash,
    input  logic               frame_tick,
    output logic               Run,
    output logic               burn,
    output logic               paused,
    output logic               game_over,
    output logic               respawn,
    output logic [LIVES_W-1:0] lives
);

    localparam int BURN_W = (BURN_FRAMES > 1) ? $clog2(BURN_FRAMES) : 1;

    game_state_t        state_q, state_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic [BURN_W-1:0]  burn_cnt_q, burn_cnt_d;
    logic               respawn_q, respawn_d;
    logic               start_press, pause_press;

    key_press_detect #(.KEY(START_KEY)) u_start_key (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .keycode (keycode),
        .press   (start_press)
    );

    key_press_detect #(.KEY(PAUSE_KEY)) u_pause_key (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .keycode (keycode),
        .press   (pause_press)
    );

    always_comb begin
        state_d    = state_q;
        lives_d    = lives_q;
        burn_cnt_d = burn_cnt_q;
        respawn_d  = 1'b0;

        case (state_q)
            START: begin
                if (start_press) begin
                    state_d = PLAY;
                    lives_d = LIVES_W'(NUM_LIVES);
                end
            end
            PLAY: begin
                // Life is charged only on entry to BURN, so a held crash costs one.
                if (crash) begin
                    state_d    = BURN;
                    lives_d    = (lives_q == '0) ? '0 : lives_q - 1'b1;
                    burn_cnt_d = BURN_W'(BURN_FRAMES - 1);
                end else if (pause_press) begin
                    state_d = PAUSE;
                end
            end
            PAUSE: begin
                if (pause_press) begin
                    state_d = PLAY;
                end
            end
            BURN: begin
                if (frame_tick) begin
                    if (burn_cnt_q != '0) begin
                        burn_cnt_d = burn_cnt_q - 1'b1;
                    end else if (lives_q == '0) begin
                        state_d = GAMEOVER;
                    end else begin
                        state_d   = PLAY;
                        respawn_d = 1'b1;
                    end
                end
            end
            GAMEOVER: begin
                if (start_press) begin
                    state_d = START;
                end
            end
            default: begin
                state_d = START;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q    <= START;
            lives_q    <= LIVES_W'(NUM_LIVES);
            burn_cnt_q <= '0;
            respawn_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            lives_q    <= lives_d;
            burn_cnt_q <= burn_cnt_d;
            respawn_q  <= respawn_d;
        end
    end

    assign Run       = (state_q == PLAY);
    assign burn      = (state_q == BURN) || (state_q == GAMEOVER);
    assign paused    = (state_q == PAUSE);
    assign game_over = (state_q == GAMEOVER);
    assign respawn   = respawn_q;
    assign lives     = lives_q;

endmodule

// File: tb/tb_game_fsm.sv
// Randomized and directed bench for game_fsm against a behavioural game model.
module tb_game_fsm;

    localparam int N_LIVES = 2;
    localparam int BF      = 4;
    localparam int LW      = $clog2(N_LIVES + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    keycode;
    logic          crash;
    logic          frame_tick;
    logic          run_o, burn_o, paused_o, game_over_o, respawn_o;
    logic [LW-1:0] lives_o;

    int checks = 0;
    int errors = 0;

    // Behavioural model: screen name, lives left, burn ticks still to wait.
    localparam int M_TITLE = 10, M_PLAY = 11, M_PAUSE = 12, M_BURN = 13, M_OVER = 14;
    int m_mode, m_lives, m_burn_left, m_prev_key;
    bit m_respawn;

    game_fsm #(
        .NUM_LIVES   (N_LIVES),
        .BURN_FRAMES (BF),
        .START_KEY   (8'd26),
        .PAUSE_KEY   (8'd19)
    ) dut (
        .Clk        (clk),
        .Reset_n    (rst_n),
        .keycode    (keycode),
        .crash      (crash),
        .frame_tick (frame_tick),
        .Run        (run_o),
        .burn       (burn_o),
        .paused     (paused_o),
        .game_over  (game_over_o),
        .respawn    (respawn_o),
        .lives      (lives_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit rn, input int key, input bit c, input bit t);
        bit sp, pp;
        if (!rn) begin
            m_mode = M_TITLE; m_lives = N_LIVES; m_burn_left = 0;
            m_respawn = 0; m_prev_key = 0;
            return;
        end
        sp = (key == 26) && (m_prev_key != 26);
        pp = (key == 19) && (m_prev_key != 19);
        m_prev_key = key;
        m_respawn = 0;
        case (m_mode)
            M_TITLE: if (sp) begin m_mode = M_PLAY; m_lives = N_LIVES; end
            M_PLAY: begin
                if (c) begin
                    m_mode = M_BURN;
                    m_lives = (m_lives > 0) ? m_lives - 1 : 0;
                    m_burn_left = BF;
                end else if (pp) m_mode = M_PAUSE;
            end
            M_PAUSE: if (pp) m_mode = M_PLAY;
            M_BURN: begin
                if (t) begin
                    m_burn_left--;
                    if (m_burn_left == 0) begin
                        if (m_lives == 0) m_mode = M_OVER;
                        else begin m_mode = M_PLAY; m_respawn = 1; end
                    end
                end
            end
            default: if (sp) m_mode = M_TITLE;
        endcase
    endtask

    task automatic compare_all();
        check("run",       32'(run_o),       32'(m_mode == M_PLAY));
        check("burn",      32'(burn_o),      32'(m_mode == M_BURN || m_mode == M_OVER));
        check("paused",    32'(paused_o),    32'(m_mode == M_PAUSE));
        check("game_over", 32'(game_over_o), 32'(m_mode == M_OVER));
        check("respawn",   32'(respawn_o),   32'(m_respawn));
        check("lives",     32'(lives_o),     32'(m_lives));
    endtask

    task automatic cycle(input bit rn, input logic [7:0] k, input bit c, input bit t);
        rst_n = rn; keycode = k; crash = c; frame_tick = t;
        @(posedge clk);
        model_step(rn, int'(k), c, t);
        #1;
        compare_all();
    endtask

    initial begin
        int respawn_cnt;
        logic [7:0] rk;
        rst_n = 1'b0; keycode = 8'd0; crash = 1'b0; frame_tick = 1'b0;

        // Reset and start
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        check("reset_lives", 32'(lives_o), 32'(N_LIVES));
        check("reset_run", 32'(run_o), 0);
        cycle(1, 26, 0, 0);
        check("start_run", 32'(run_o), 1);
        for (int i = 0; i < 9; i++) cycle(1, 26, 0, 0);

        // Pause toggle
        cycle(1, 0, 0, 0);
        cycle(1, 19, 0, 0);
        check("pause_paused", 32'(paused_o), 1);
        check("pause_run", 32'(run_o), 0);
        cycle(1, 0, 0, 0);
        cycle(1, 19, 0, 0);
        check("unpause_run", 32'(run_o), 1);
        cycle(1, 0, 0, 0);

        // Held crash costs one life, then respawn after BF ticks
        for (int i = 0; i < 20; i++) cycle(1, 0, 1, 0);
        check("crash_lives", 32'(lives_o), 32'(N_LIVES - 1));
        respawn_cnt = 0;
        for (int i = 0; i < BF; i++) begin
            cycle(1, 0, 0, 1);
            if (respawn_o) respawn_cnt++;
            cycle(1, 0, 0, 0);
            if (respawn_o) respawn_cnt++;
        end
        check("respawn_pulses", 32'(respawn_cnt), 1);
        check("respawn_run", 32'(run_o), 1);

        // Crash with simultaneous pause edge, last life -> game over
        cycle(1, 19, 1, 0);
        check("simul_paused", 32'(paused_o), 0);
        check("simul_burn", 32'(burn_o), 1);
        for (int i = 0; i < BF; i++) cycle(1, 0, 0, 1);
        check("over_flag", 32'(game_over_o), 1);
        check("over_lives", 32'(lives_o), 0);
        cycle(1, 26, 0, 0);
        check("over_ack_burn", 32'(burn_o), 0);
        check("over_ack_run", 32'(run_o), 0);
        cycle(1, 0, 0, 0);
        cycle(1, 26, 0, 0);
        check("replay_lives", 32'(lives_o), 32'(N_LIVES));

        // Pause ignores crash and frame ticks
        cycle(1, 0, 0, 0);
        cycle(1, 19, 0, 0);
        for (int i = 0; i < 6; i++) cycle(1, 0, 1, 1);
        check("pause_frozen", 32'(paused_o), 1);
        cycle(1, 19, 0, 0);

        // Reset mid-burn
        cycle(1, 0, 1, 0);
        cycle(1, 0, 0, 1);
        cycle(1, 0, 0, 1);
        cycle(0, 0, 0, 0);
        check("midburn_burn", 32'(burn_o), 0);
        check("midburn_lives", 32'(lives_o), 32'(N_LIVES));

        // Start key held across reset and for 100 cycles
        cycle(0, 26, 0, 0);
        for (int i = 0; i < 100; i++) cycle(1, 26, 0, 0);
        check("held_run", 32'(run_o), 1);

        // Random play
        for (int i = 0; i < 4000; i++) begin
            case ($urandom_range(0, 5))
                0, 1: rk = 8'd0;
                2:    rk = 8'd26;
                3:    rk = 8'd19;
                4:    rk = keycode;
                default: rk = 8'($urandom);
            endcase
            cycle(($urandom_range(0, 299) != 0), rk,
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 2) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
